// File: rtl/mode_request_arbiter_if.sv
// mode_request_arbiter_if: request pulses and 1 Hz tick into the mode sequencer,
// registered mode/grant/timer status back out to the hood controllers.
interface mode_request_arbiter_if #(parameter int MODE_WIDTH = 3);
    logic                  sec_tick;
    logic                  req_power;
    logic                  req_menu;
    logic                  req_clean;
    logic [2:0]            req_level;
    logic [MODE_WIDTH-1:0] current_mode;
    logic                  mode_changed;
    logic [5:0]            grant;
    logic [15:0]           remain_secs;
    logic                  l3_used;
    modport master (
        output sec_tick, req_power, req_menu, req_clean, req_level,
        input  current_mode, mode_changed, grant, remain_secs, l3_used
    );
    modport slave (
        input  sec_tick, req_power, req_menu, req_clean, req_level,
        output current_mode, mode_changed, grant, remain_secs, l3_used
    );
endinterface

// File: rtl/mode_request_arbiter.sv
// mode_request_arbiter: fixed-priority mode sequencer with timed L3/CLEAN/COOLDOWN modes.
// L3_ONCE_PER_POWERON_EN: when defined, L3 may be entered only once per power-on.
module mode_request_arbiter #(
    parameter int MODE_WIDTH    = 3,
    parameter int CLEAN_SECS    = 180,
    parameter int L3_SECS       = 60,
    parameter int COOLDOWN_SECS = 60
) (
    input logic clk,
    input logic rst,
    mode_request_arbiter_if.slave bus
);
    localparam logic [MODE_WIDTH-1:0] OFF      = MODE_WIDTH'(0);
    localparam logic [MODE_WIDTH-1:0] STANDBY  = MODE_WIDTH'(1);
    localparam logic [MODE_WIDTH-1:0] L1       = MODE_WIDTH'(2);
    localparam logic [MODE_WIDTH-1:0] L2       = MODE_WIDTH'(3);
    localparam logic [MODE_WIDTH-1:0] L3       = MODE_WIDTH'(4);
    localparam logic [MODE_WIDTH-1:0] CLEAN    = MODE_WIDTH'(5);
    localparam logic [MODE_WIDTH-1:0] COOLDOWN = MODE_WIDTH'(6);

    logic [MODE_WIDTH-1:0] mode, next_mode, power_tgt, menu_tgt, expire_tgt;
    logic [15:0]           timer, next_timer, load_val;
    logic [5:0]            req, legal, lr, gnt, grant_q;
    logic                  l3_q, next_l3, l3_ok, timed, expire, entry, changed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= OFF;
            timer     <= '0;
            l3_q      <= 1'b0;
            grant_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            mode      <= next_mode;
            timer     <= next_timer;
            l3_q      <= next_l3;
            grant_q   <= gnt;
            changed_q <= entry;
        end
    end

    always_comb begin
`ifdef L3_ONCE_PER_POWERON_EN
        l3_ok      = ~l3_q;
`else
        l3_ok      = 1'b1;
`endif
        req        = {bus.req_power, bus.req_menu, bus.req_clean, bus.req_level[2], bus.req_level[1], bus.req_level[0]};
        // legal request mask per mode, bit order {power, menu, clean, L3, L2, L1}
        legal      = (mode == OFF)                       ? 6'b100000 :
                     (mode == STANDBY)                   ? {3'b101, l3_ok, 2'b11} :
                     (mode == L1 || mode == L2)          ? {3'b110, l3_ok, 2'b11} :
                     (mode == L3)                        ? 6'b110000 :
                     (mode == CLEAN || mode == COOLDOWN) ? 6'b100000 : 6'b000000;
        lr         = req & legal;
        gnt        = lr[5] ? 6'b100000 : lr[4] ? 6'b010000 : lr[3] ? 6'b001000 :
                     lr[2] ? 6'b000100 : lr[1] ? 6'b000010 : lr[0] ? 6'b000001 : 6'b000000;
        timed      = (mode == L3) || (mode == CLEAN) || (mode == COOLDOWN);
        expire     = timed && (timer == 16'd1) && bus.sec_tick;
        power_tgt  = (mode == OFF || mode == COOLDOWN) ? STANDBY :
                     (mode == STANDBY || mode == CLEAN) ? OFF : COOLDOWN;
        menu_tgt   = (mode == L3) ? COOLDOWN : STANDBY;
        expire_tgt = (mode == L3) ? L2 : (mode == CLEAN) ? STANDBY : OFF;
        // a granted request always beats a coincident timer expiry
        next_mode  = gnt[5] ? power_tgt : gnt[4] ? menu_tgt : gnt[3] ? CLEAN :
                     gnt[2] ? L3 : gnt[1] ? L2 : gnt[0] ? L1 :
                     expire ? expire_tgt : (mode > COOLDOWN) ? OFF : mode;
        entry      = next_mode != mode;
        load_val   = (next_mode == CLEAN) ? 16'(CLEAN_SECS) :
                     (next_mode == L3)    ? 16'(L3_SECS) :
                     (next_mode == COOLDOWN) ? 16'(COOLDOWN_SECS) : 16'd0;
        next_timer = entry ? load_val :
                     !timed ? 16'd0 :
                     (bus.sec_tick && timer != 16'd0) ? timer - 16'd1 : timer;
`ifdef L3_ONCE_PER_POWERON_EN
        next_l3    = (entry && next_mode == L3) ? 1'b1 :
                     (entry && next_mode == OFF) ? 1'b0 : l3_q;
`else
        next_l3    = 1'b0;
`endif
    end

    always_comb begin
        bus.current_mode = mode;
        bus.mode_changed = changed_q;
        bus.grant        = grant_q;
        bus.remain_secs  = timer;
        bus.l3_used      = l3_q;
    end
endmodule

// File: tb/tb_mode_request_arbiter.sv
// tb_mode_request_arbiter: directed vectors with a queued scoreboard and negedge monitor.
module tb_mode_request_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef L3_ONCE_PER_POWERON_EN
    localparam logic ONCE = 1'b1;
`else
    localparam logic ONCE = 1'b0;
`endif

    typedef struct {
        string       name;
        int          due;
        logic [2:0]  mode;
        logic [5:0]  grant;
        logic        mc;
        logic [15:0] rem;
        logic        l3;
    } exp_t;
    exp_t q[$];

    mode_request_arbiter_if #(.MODE_WIDTH(3)) bus ();
    mode_request_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (bus.current_mode !== e.mode || bus.grant !== e.grant || bus.mode_changed !== e.mc ||
                bus.remain_secs !== e.rem || bus.l3_used !== e.l3) begin
                miscompares++;
                $display("FAIL %s: got mode=%0d grant=%b chg=%b rem=%0d l3=%b, want mode=%0d grant=%b chg=%b rem=%0d l3=%b",
                         e.name, bus.current_mode, bus.grant, bus.mode_changed, bus.remain_secs, bus.l3_used,
                         e.mode, e.grant, e.mc, e.rem, e.l3);
            end
        end
    end

    task automatic step(input logic r, p, m, c, input logic [2:0] lv, input logic t, input string nm,
                        input logic [2:0] em, input logic [5:0] eg, input logic emc,
                        input logic [15:0] er, input logic el);
        @(negedge clk);
        rst = r;
        bus.req_power = p;
        bus.req_menu = m;
        bus.req_clean = c;
        bus.req_level = lv;
        bus.sec_tick = t;
        q.push_back('{name: nm, due: cyc + 1, mode: em, grant: eg, mc: emc, rem: er, l3: el});
    endtask

    task automatic idle(input int n, input logic t);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0;
            bus.req_power = 1'b0;
            bus.req_menu = 1'b0;
            bus.req_clean = 1'b0;
            bus.req_level = 3'b000;
            bus.sec_tick = t;
        end
    endtask

    initial begin
        bus.req_power = 1'b0;
        bus.req_menu = 1'b0;
        bus.req_clean = 1'b0;
        bus.req_level = 3'b000;
        bus.sec_tick = 1'b0;
        //    r  p  m  c  lvl     t   name            mode grant      chg rem  l3
        step(1, 0, 0, 0, 3'b000, 0, "reset",         0, 6'b000000, 0, 0,   0);
        step(0, 1, 0, 0, 3'b000, 0, "power_on",      1, 6'b100000, 1, 0,   0);
        step(0, 0, 0, 0, 3'b010, 0, "stby_to_l2",    3, 6'b000010, 1, 0,   0);
        step(0, 1, 0, 1, 3'b001, 0, "prio_power",    6, 6'b100000, 1, 60,  0);
        step(0, 0, 0, 0, 3'b000, 1, "cd_tick",       6, 6'b000000, 0, 59,  0);
        step(0, 1, 0, 0, 3'b000, 0, "cd_cancel",     1, 6'b100000, 1, 0,   0);
        step(0, 0, 0, 0, 3'b100, 0, "enter_l3",      4, 6'b000100, 1, 60,  ONCE);
        idle(58, 1);
        step(0, 0, 0, 0, 3'b000, 1, "l3_last_sec",   4, 6'b000000, 0, 1,   ONCE);
        step(0, 0, 0, 0, 3'b000, 1, "l3_expire",     3, 6'b000000, 1, 0,   ONCE);
`ifdef L3_ONCE_PER_POWERON_EN
        step(0, 0, 0, 0, 3'b100, 0, "l3_reuse_drop", 3, 6'b000000, 0, 0,   1);
        step(0, 0, 1, 0, 3'b000, 0, "l2_menu",       1, 6'b010000, 1, 0,   1);
`else
        step(0, 0, 0, 0, 3'b100, 0, "l3_reenter",    4, 6'b000100, 1, 60,  0);
        step(0, 0, 1, 0, 3'b000, 0, "l3_menu",       6, 6'b010000, 1, 60,  0);
        step(0, 1, 0, 0, 3'b000, 0, "cd_cancel2",    1, 6'b100000, 1, 0,   0);
`endif
        step(0, 0, 0, 1, 3'b000, 0, "enter_clean",   5, 6'b001000, 1, 180, ONCE);
        step(0, 0, 0, 0, 3'b000, 1, "clean_tick",    5, 6'b000000, 0, 179, ONCE);
        step(0, 0, 0, 0, 3'b111, 1, "clean_lvl_ign", 5, 6'b000000, 0, 178, ONCE);
        step(0, 0, 1, 0, 3'b000, 0, "clean_menu_ign",5, 6'b000000, 0, 178, ONCE);
        idle(128, 1);
        step(0, 1, 0, 0, 3'b000, 0, "clean_abort",   0, 6'b100000, 1, 0,   0);
        step(0, 1, 0, 0, 3'b000, 0, "power_on2",     1, 6'b100000, 1, 0,   0);
        step(0, 0, 0, 0, 3'b001, 0, "stby_to_l1",    2, 6'b000001, 1, 0,   0);
        step(0, 1, 0, 0, 3'b000, 0, "l1_power",      6, 6'b100000, 1, 60,  0);
        idle(59, 1);
        step(0, 1, 0, 0, 3'b000, 1, "cd_grant_wins", 1, 6'b100000, 1, 0,   0);
        step(0, 0, 0, 0, 3'b001, 0, "stby_to_l1b",   2, 6'b000001, 1, 0,   0);
        step(0, 1, 0, 0, 3'b000, 0, "l1_power2",     6, 6'b100000, 1, 60,  0);
        idle(59, 1);
        step(0, 0, 0, 0, 3'b000, 1, "cd_expire",     0, 6'b000000, 1, 0,   0);
        step(0, 1, 0, 0, 3'b000, 0, "power_on3",     1, 6'b100000, 1, 0,   0);
        step(0, 0, 1, 0, 3'b000, 0, "stby_menu_ign", 1, 6'b000000, 0, 0,   0);
        step(0, 0, 0, 0, 3'b001, 0, "stby_to_l1c",   2, 6'b000001, 1, 0,   0);
        step(0, 0, 0, 0, 3'b001, 0, "l1_same",       2, 6'b000001, 0, 0,   0);
        step(0, 0, 0, 1, 3'b000, 0, "l1_clean_ign",  2, 6'b000000, 0, 0,   0);
        step(0, 0, 0, 0, 3'b100, 0, "l1_to_l3",      4, 6'b000100, 1, 60,  ONCE);
        step(1, 0, 0, 0, 3'b000, 1, "mid_reset",     0, 6'b000000, 0, 0,   0);
        step(0, 0, 0, 0, 3'b000, 1, "post_reset",    0, 6'b000000, 0, 0,   0);
        idle(1, 0);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
            miscompares += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
